// File: rtl/counter_dff.sv
// 3-bit synchronous up/down counter built from three D flip-flops.
// mode=0 counts up, mode=1 counts down; reset is synchronous, active-high.

module counter_dff_bit (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_q <= 1'b0;
    else       r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

module counter_dff (
  input  logic       reset,
  input  logic       clk,
  input  logic       mode,
  output logic [2:0] count
);

  logic [2:0] w_q;
  logic [2:0] w_d;
  logic       w_t1;
  logic       w_t2;

  // Toggle terms: a bit flips when all lower bits are 1 (up) or 0 (down).
  assign w_t1 = w_q[0] ^ mode;
  assign w_t2 = (w_q[1] ^ mode) & (w_q[0] ^ mode);

  assign w_d[0] = ~reset & ~w_q[0];
  assign w_d[1] = ~reset & (w_q[1] ^ w_t1);
  assign w_d[2] = ~reset & (w_q[2] ^ w_t2);

  counter_dff_bit u_ff0 (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (w_d[0]),
    .o_q   (w_q[0])
  );

  counter_dff_bit u_ff1 (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (w_d[1]),
    .o_q   (w_q[1])
  );

  counter_dff_bit u_ff2 (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (w_d[2]),
    .o_q   (w_q[2])
  );

  assign count = w_q;

endmodule

// File: tb/tb_counter_dff.sv
// Self-checking bench for counter_dff: scoreboard of expected counts
// pushed at each rising edge and compared 1 ns later.

module tb_counter_dff;

  logic       clk;
  logic       reset;
  logic       mode;
  logic [2:0] count;

  logic [2:0] m_q;
  logic [2:0] sb [$];
  int         n_pass;
  int         n_chk;

  counter_dff dut (
    .reset (reset),
    .clk   (clk),
    .mode  (mode),
    .count (count)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [2:0] exp);
    n_chk++;
    assert (count === exp) n_pass++;
    else $error("FAIL %s: count=%0d expected=%0d", tag, count, exp);
  endtask

  // One rising edge: predict from the reference model, then compare.
  task automatic tick(input string tag);
    logic [2:0] e;
    @(posedge clk);
    if (reset)     m_q = 3'd0;
    else if (mode) m_q = m_q - 3'd1;
    else           m_q = m_q + 3'd1;
    sb.push_back(m_q);
    #1;
    n_chk++;
    assert (sb.size() > 0) n_pass++;
    else $error("FAIL %s: scoreboard empty size=%0d expected=1", tag, sb.size());
    e = sb.pop_front();
    check(tag, e);
  endtask

  initial begin
    n_pass = 0;
    n_chk  = 0;
    m_q    = 3'd0;
    reset  = 1'b1;
    mode   = 1'b0;

    tick("reset");
    #4 reset = 1'b0;

    for (int i = 0; i < 10; i++) tick("up");
    check("up_at_210", 3'd2);

    #4 mode = 1'b1;
    check("no_comb_mode", m_q);

    for (int i = 0; i < 4; i++) tick("down_wrap");
    check("down_at_290", 3'd6);
    for (int i = 0; i < 6; i++) tick("down");

    #4 reset = 1'b1;
    check("no_comb_reset", m_q);
    tick("reset_mid");
    check("reset_mid_zero", 3'd0);
    tick("reset_hold");

    for (int i = 0; i < 4; i++) begin
      #4 mode = ~mode;
      tick("reset_prio");
    end

    #4 reset = 1'b0;
    mode = 1'b0;
    for (int i = 0; i < 3; i++) tick("up2");

    #2 reset = 1'b1;
    #4 reset = 1'b0;
    check("pulse_no_effect", m_q);
    tick("sync_pulse");
    check("sync_pulse_val", 3'd4);

    #4 mode = 1'b1;
    for (int i = 0; i < 6; i++) tick("down2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/counter_dff.md
# counter_dff

Three-bit synchronous up/down counter built from D flip-flops. A single mode input selects the count direction, and the 3-bit state is presented directly on `count`. It is a leaf block with no parameters, intended as a small sequencing/count source and as the D-flip-flop reference against which the JK-flip-flop variant of the same counter is compared.

## Interface
- Parameters: none (width fixed at 3 bits).
- `clk`  input  1  rising-edge clock; the only clock.
- `reset`  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- `mode`  input  1  direction select: 0 = count up, 1 = count down.
- `count`  output  3  current counter state, driven directly from the three flip-flop Q outputs.
- Positional port order is fixed at (`reset`, `clk`, `mode`, `count`), because instantiating code connects by position.

## Operation
- State: three D flip-flops, Q2..Q0, with `count` = {Q2, Q1, Q0}.
  - Each bit is a separate D flip-flop instance with a synchronous active-high reset.
  - Next state is pure combinational logic (gates/expressions) feeding each D input.
- Reset: when `reset` = 1 at a rising edge, next `count` = 3'b000, regardless of `mode`. Reset has priority over counting.
- Up mode (`mode` = 0): next = count + 1 mod 8, giving 0,1,2,3,4,5,6,7,0,...
  - Wrap: 7 -> 0 with no flag and no stall.
- Down mode (`mode` = 1): next = count - 1 mod 8, giving 7,6,...,1,0,7,...
  - Wrap: 0 -> 7.
- Next-state equations (up: m = 0, down: m = 1):
  - D0 = ~Q0
  - D1 = Q1 ^ (Q0 ^ m)
  - D2 = Q2 ^ ((Q1 ^ m) & (Q0 ^ m))
  - All D inputs are forced to 0 when `reset` = 1.
- Mode change mid-count: the counter continues from its current value in the new direction on the next edge. There is no reload and no skipped value.
- Reset mid-operation: the counter returns to 0 on the first rising edge with `reset` high and holds 0 while `reset` stays high.
- Before the first reset edge, `count` is undefined (X in simulation). Users must apply reset for at least one edge.
- No enable input: the counter advances on every rising edge when not in reset.

## Timing
- All state changes occur only on rising `clk` edges. `count` changes only after an edge (clock-to-Q), never combinationally from `mode` or `reset`.
- Latency:
  - `reset` asserted -> `count` = 0 after the next rising edge.
  - `reset` deasserted -> the first increment/decrement happens on the first rising edge that samples `reset` = 0.
- `mode` is sampled at each rising edge. A change between edges takes effect on the next edge only.
- One count step per clock; the sequence period is 8 clocks in either direction.
- `reset` and `mode` must be stable around the rising edge (setup/hold). Asynchronous changes of `reset` between edges have no effect on `count`.

## Test plan
- Reset: clk period 20 ns (first rise at 10 ns), `reset` = 1 and `mode` = 0 until 15 ns -> `count` = 0 after the 10 ns edge.
- Up count and wrap: `reset` released at 15 ns, `mode` = 0 -> `count` = 1 at 30 ns, 7 at 150 ns, 0 at 170 ns, 2 at 210 ns.
- Direction switch: `mode` = 1 at 215 ns -> `count` = 1 at 230 ns, 0 at 250 ns, 7 at 270 ns, 6 at 290 ns, then continues down.
- Reset mid-count: `reset` = 1 at 415 ns while counting down -> `count` = 0 at the 430 ns edge and holds 0 at 450 ns.
- Reset priority: `reset` = 1 with `mode` toggling every cycle -> `count` stays 0 on every edge.
- Sync-reset check: a `reset` pulse that rises and falls between two rising edges -> `count` continues its sequence unaffected.
